// File: rtl/encoder_pkg.sv
// Shared definitions for the 4-to-2 arbitrating encoder: request count and FSM state type.
package encoder_pkg;

   localparam int N_REQ = 4;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational selector: scans req upward from ptr (modulo 4) and returns the first set bit.
// With ptr tied to zero this reduces to a lowest-index-wins priority encoder.
module rr_pick4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [1:0] idx,
   output logic       any
);

   logic       found;
   logic [1:0] pos;

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path can infer a latch.
      idx   = ptr;
      found = 1'b0;
      pos   = ptr;
      for (int k = 0; k < 4; k++) begin
         // Two-bit addition wraps 3 back to 0 without an explicit modulo.
         pos = ptr + 2'(k);
         if (!found && req[pos]) begin
            idx   = pos;
            found = 1'b1;
         end
      end
      any = |req;
   end

endmodule

// File: rtl/encoder4x2_arb.sv
// Registered 4-to-2 encoder with valid/ready hold. Define ENCODER_RR_EN for round-robin
// selection; otherwise the scan pointer is tied to zero and the lowest set request wins.
module encoder4x2_arb #(
   parameter int N_REQ = encoder_pkg::N_REQ
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] req,
   input  logic       ready,
   output logic [1:0] idx,
   output logic       valid
);

   import encoder_pkg::state_t;
   import encoder_pkg::IDLE;
   import encoder_pkg::HOLD;

   if (N_REQ != 4) begin : g_bad_n_req
      $error("encoder4x2_arb supports only N_REQ = 4");
   end

   state_t     state;
   state_t     state_next;
   logic [1:0] ptr;
   logic [1:0] pick_idx;
   logic       pick_any;
   logic       grant;
   logic       handshake;

   rr_pick4 u_pick (
      .req (req),
      .ptr (ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   // State register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (enable && pick_any) state_next = HOLD;
         HOLD: if (ready)              state_next = IDLE;
         default:                      state_next = IDLE;
      endcase
   end

   // Output and strobe decode; enable is deliberately ignored while holding.
   always_comb begin
      valid     = (state == HOLD);
      grant     = (state == IDLE) && enable && pick_any;
      handshake = (state == HOLD) && ready;
   end

   always_ff @(posedge clk) begin
      if (reset)      idx <= 2'b00;
      else if (grant) idx <= pick_idx;
   end

`ifdef ENCODER_RR_EN
   // The winner drops to lowest priority once the consumer has taken it.
   always_ff @(posedge clk) begin
      if (reset)          ptr <= 2'b00;
      else if (handshake) ptr <= idx + 2'd1;
   end
`else
   assign ptr = 2'b00;
`endif

endmodule

// File: tb/tb_encoder4x2_arb.sv
// Self-checking bench for encoder4x2_arb: directed scenarios plus random traffic,
// all compared cycle by cycle against a behavioural model of grant/hold/handshake.
module tb_encoder4x2_arb;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [3:0] req;
   logic       ready;
   logic [1:0] idx;
   logic       valid;

   int checks   = 0;
   int failures = 0;

   // Model state
   bit m_valid;
   int m_idx;
   int m_ptr;

   encoder4x2_arb dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .req    (req),
      .ready  (ready),
      .idx    (idx),
      .valid  (valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // First set bit scanning upward from p, wrapping modulo 4.
   function automatic int first_from(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return 0;
   endfunction

   task automatic model_edge();
      if (reset) begin
         m_valid = 1'b0;
         m_idx   = 0;
         m_ptr   = 0;
      end else if (!m_valid) begin
         if (enable && req != 4'b0000) begin
            m_idx   = first_from(req, m_ptr);
            m_valid = 1'b1;
         end
      end else if (ready) begin
         m_valid = 1'b0;
`ifdef ENCODER_RR_EN
         m_ptr = (m_idx + 1) % 4;
`endif
      end
   endtask

   // Apply inputs, clock once, then compare all observable state against the model.
   task automatic step(input logic r, input logic en, input logic [3:0] rq, input logic rdy);
      reset  = r;
      enable = en;
      req    = rq;
      ready  = rdy;
      @(posedge clk);
      model_edge();
      #1;
      check("valid", int'(valid), int'(m_valid));
      check("idx", int'(idx), m_idx);
      check("ptr", int'(dut.ptr), m_ptr);
   endtask

   initial begin
      int exp_seq[5];
      reset = 1'b1; enable = 1'b0; req = 4'b0000; ready = 1'b0;
      step(1'b1, 1'b0, 4'b0000, 1'b0);
      step(1'b1, 1'b1, 4'b1111, 1'b1);
      check("reset_valid", int'(valid), 0);

      // One-hot sweep: each grant valid for one cycle, then a bubble.
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 4'(1 << i), 1'b1);
         check("onehot_idx", int'(idx), i);
         check("onehot_valid", int'(valid), 1);
         step(1'b0, 1'b1, 4'(1 << i), 1'b1);
         check("onehot_bubble", int'(valid), 0);
      end

      // Backpressure: idx and valid frozen while ready is low, whatever req/enable do.
      step(1'b0, 1'b1, 4'b0100, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'(i % 2), 4'b0001, 1'b0);
         check("bp_idx", int'(idx), 2);
         check("bp_valid", int'(valid), 1);
      end
      step(1'b0, 1'b1, 4'b0000, 1'b1);
      check("bp_release", int'(valid), 0);

      // Reset while holding idx=2.
      step(1'b0, 1'b1, 4'b0100, 1'b0);
      check("pre_reset_idx", int'(idx), 2);
      step(1'b1, 1'b1, 4'b0100, 1'b0);
      check("mid_hold_reset_valid", int'(valid), 0);
      check("mid_hold_reset_idx", int'(idx), 0);
      check("mid_hold_reset_ptr", int'(dut.ptr), 0);

      // Sustained all-request traffic.
`ifdef ENCODER_RR_EN
      exp_seq = '{0, 1, 2, 3, 0};
`else
      exp_seq = '{0, 0, 0, 0, 0};
`endif
      for (int g = 0; g < 5; g++) begin
         step(1'b0, 1'b1, 4'b1111, 1'b1);
         check("all_req_grant", int'(idx), exp_seq[g]);
         step(1'b0, 1'b1, 4'b1111, 1'b1);
      end

`ifdef ENCODER_RR_EN
      step(1'b1, 1'b0, 4'b0000, 1'b0);
      for (int g = 0; g < 4; g++) begin
         step(1'b0, 1'b1, 4'b1111, 1'b1);
         step(1'b0, 1'b1, 4'b1111, 1'b1);
      end
      step(1'b0, 1'b1, 4'b1001, 1'b1);
      check("rr_wrap_1001", int'(idx), 0);
      step(1'b0, 1'b1, 4'b1001, 1'b1);
`else
      step(1'b0, 1'b1, 4'b1100, 1'b1);
      check("fixed_1100", int'(idx), 2);
      step(1'b0, 1'b1, 4'b1100, 1'b1);
`endif

      // Idle guard: no grant without both enable and a request.
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 4'b1111, 1'b1);
         check("guard_en0", int'(valid), 0);
         step(1'b0, 1'b1, 4'b0000, 1'b1);
         check("guard_req0", int'(valid), 0);
      end

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) != 0),
              4'($urandom), 1'($urandom_range(0, 2) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
